if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the pre-IF PC register.
- Takes one fetch PC per handshake and issues one 64-bit aligned read on the SRAM-like instruction bus (req/addr_ok/data_ok) that fronts the AXI bridge.
- Holds the returned instruction pair until the ID stage accepts it.
- Supports dual issue: one or two instructions per fetch. Keeps at most one bus transaction outstanding and squashes it cleanly on an exception flush.

---
 rtl/if_fetch_stage.sv | 127 ++++++++++++
 tb/tb_if_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one 64-bit aligned read per accepted PC, at most one bus
// transaction in flight, and clean squash of that transaction on an exception flush.
module if_fetch_stage #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              excep_flush_i,
    input  logic              preif_valid_i,
    input  logic [PC_W-1:0]   preif_pc_i,
    output logic              if_allowin_o,
    output logic              inst_req_o,
    output logic [PC_W-1:0]   inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    input  logic              id_allowin_i,
    output logic              if_valid_o,
    output logic [PC_W-1:0]   if_pc_o,
    output logic [31:0]       if_inst0_o,
    output logic [31:0]       if_inst1_o,
    output logic              if_inst1_valid_o,
    output logic              if_adef_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP_REQ,
        S_DROP_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_inst0;
    logic [31:0]       r_inst1;
    logic              r_inst1_valid;
    logic              r_adef;
    logic              w_allowin;
    logic              w_accept;
    logic              w_adef;
    logic              w_capture;

    // Gated by rst so the stage never advertises room while held in reset.
    assign w_allowin = !rst && !excep_flush_i &&
                       ((r_state == S_IDLE) || ((r_state == S_HOLD) && id_allowin_i));
    assign w_accept  = preif_valid_i && w_allowin;
    assign w_adef    = (preif_pc_i[1:0] != 2'b00);
    assign w_capture = (r_state == S_WAIT) && inst_data_ok_i && !excep_flush_i;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_adef ? S_HOLD : S_REQ;
            end
            S_REQ: begin
                if (excep_flush_i)       w_next = inst_addr_ok_i ? S_DROP_RESP : S_DROP_REQ;
                else if (inst_addr_ok_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (excep_flush_i)       w_next = inst_data_ok_i ? S_IDLE : S_DROP_RESP;
                else if (inst_data_ok_i) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (excep_flush_i)     w_next = S_IDLE;
                else if (w_accept)     w_next = w_adef ? S_HOLD : S_REQ;
                else if (id_allowin_i) w_next = S_IDLE;
            end
            S_DROP_REQ: begin
                if (inst_addr_ok_i) w_next = S_DROP_RESP;
            end
            S_DROP_RESP: begin
                if (inst_data_ok_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= '0;
            r_inst0       <= '0;
            r_inst1       <= '0;
            r_inst1_valid <= 1'b0;
            r_adef        <= 1'b0;
        end else if (w_accept) begin
            r_pc          <= preif_pc_i;
            r_inst0       <= '0;
            r_inst1       <= '0;
            r_inst1_valid <= 1'b0;
            r_adef        <= w_adef;
        end else if (w_capture) begin
            if (r_pc[2]) begin
                r_inst0       <= inst_rdata_i[63:32];
                r_inst1       <= '0;
                r_inst1_valid <= 1'b0;
            end else begin
                r_inst0       <= inst_rdata_i[31:0];
                r_inst1       <= inst_rdata_i[63:32];
                r_inst1_valid <= 1'b1;
            end
        end
    end

    assign if_allowin_o     = w_allowin;
    assign inst_req_o       = (r_state == S_REQ) || (r_state == S_DROP_REQ);
    assign inst_addr_o      = {r_pc[PC_W-1:3], 3'b000};
    assign if_valid_o       = (r_state == S_HOLD);
    assign if_pc_o          = r_pc;
    assign if_inst0_o       = r_inst0;
    assign if_inst1_o       = r_inst1;
    assign if_inst1_valid_o = r_inst1_valid;
    assign if_adef_o        = r_adef;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic, all checked against
// a transaction-level model (pending request / pending response / held pair).
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        pv;
    logic [31:0] ppc;
    logic        allowin;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] rdata;
    logic        id_allow;
    logic        vld;
    logic [31:0] opc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        i1v;
    logic        adef;

    // Reference model: what the stage owes the bus and the ID stage.
    logic        m_req;
    logic        m_resp;
    logic        m_squash;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_i0;
    logic [31:0] m_i1;
    logic        m_i1v;
    logic        m_adef;

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch_stage #(.PC_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst), .excep_flush_i(flush),
        .preif_valid_i(pv), .preif_pc_i(ppc), .if_allowin_o(allowin),
        .inst_req_o(req), .inst_addr_o(addr), .inst_addr_ok_i(addr_ok),
        .inst_data_ok_i(data_ok), .inst_rdata_i(rdata), .id_allowin_i(id_allow),
        .if_valid_o(vld), .if_pc_o(opc), .if_inst0_o(i0), .if_inst1_o(i1),
        .if_inst1_valid_o(i1v), .if_adef_o(adef)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic exp_allow();
        return !rst && !flush && !m_req && !m_resp && (!m_valid || id_allow);
    endfunction

    task automatic model_clear();
        m_req = 1'b0; m_resp = 1'b0; m_squash = 1'b0; m_valid = 1'b0;
        m_pc = '0; m_i0 = '0; m_i1 = '0; m_i1v = 1'b0; m_adef = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_allowin"}, allowin, 0);
        chk({tag, "_req"},     req,     0);
        chk({tag, "_addr"},    addr,    0);
        chk({tag, "_valid"},   vld,     0);
        chk({tag, "_pc"},      opc,     0);
        chk({tag, "_inst0"},   i0,      0);
        chk({tag, "_inst1"},   i1,      0);
        chk({tag, "_i1v"},     i1v,     0);
        chk({tag, "_adef"},    adef,    0);
    endtask

    task automatic check_outputs();
        chk("allowin", allowin, exp_allow());
        chk("req", req, m_req);
        if (m_req) chk("addr", addr, {m_pc[31:3], 3'b000});
        chk("valid", vld, m_valid);
        if (m_valid) begin
            chk("pc",    opc,  m_pc);
            chk("inst0", i0,   m_i0);
            chk("inst1", i1,   m_i1);
            chk("i1v",   i1v,  m_i1v);
            chk("adef",  adef, m_adef);
        end
    endtask

    task automatic model_edge();
        logic acc;
        logic was_valid;
        acc       = pv && exp_allow();
        was_valid = m_valid;
        if (rst) begin
            model_clear();
        end else if (flush) begin
            m_valid = 1'b0;
            if (m_req) begin
                m_squash = 1'b1;
                if (addr_ok) begin m_req = 1'b0; m_resp = 1'b1; end
            end else if (m_resp) begin
                if (data_ok) begin m_resp = 1'b0; m_squash = 1'b0; end
                else m_squash = 1'b1;
            end
        end else begin
            if (m_req && addr_ok) begin
                m_req = 1'b0; m_resp = 1'b1;
            end else if (m_resp && data_ok) begin
                m_resp = 1'b0;
                if (!m_squash) begin
                    m_valid = 1'b1;
                    m_adef  = 1'b0;
                    if (m_pc[2]) begin m_i0 = rdata[63:32]; m_i1 = '0; m_i1v = 1'b0; end
                    else begin m_i0 = rdata[31:0]; m_i1 = rdata[63:32]; m_i1v = 1'b1; end
                end
                m_squash = 1'b0;
            end else if (was_valid && id_allow) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                m_pc = ppc;
                if (ppc[1:0] != 2'b00) begin
                    m_valid = 1'b1; m_adef = 1'b1; m_i0 = '0; m_i1 = '0; m_i1v = 1'b0;
                end else begin
                    m_valid = 1'b0; m_req = 1'b1; m_adef = 1'b0;
                end
            end
        end
    endtask

    // Compare mid-cycle, advance the model across the edge, then return just after it.
    task automatic cyc();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; pv = 1'b0; ppc = '0; addr_ok = 1'b0; data_ok = 1'b0;
        rdata = '0; id_allow = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_clear();
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();

        // Normal fetch, both instructions usable.
        pv = 1'b1; ppc = 32'h1C00_0000;
        cyc();
        pv = 1'b0; addr_ok = 1'b1;
        chk("tp_req", req, 1);
        chk("tp_addr", addr, 32'h1C00_0000);
        cyc();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 64'h0000_0002_0000_0001;
        cyc();
        data_ok = 1'b0;
        chk("tp_valid", vld, 1);
        chk("tp_inst0", i0, 32'h1);
        chk("tp_inst1", i1, 32'h2);
        chk("tp_i1v", i1v, 1);
        cyc();

        // Odd word, then backpressure in HOLD.
        pv = 1'b1; ppc = 32'h1C00_0004;
        cyc();
        pv = 1'b0; addr_ok = 1'b1;
        chk("odd_addr", addr, 32'h1C00_0000);
        cyc();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 64'hAAAA_0000_BBBB_0000;
        cyc();
        data_ok = 1'b0; id_allow = 1'b0; pv = 1'b1; ppc = 32'h1C00_0008;
        chk("odd_inst0", i0, 32'hAAAA_0000);
        chk("odd_i1v", i1v, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_allowin", allowin, 0);
            chk("bp_inst0", i0, 32'hAAAA_0000);
            cyc();
        end
        id_allow = 1'b1;
        #1;
        chk("bp_release_allowin", allowin, 1);
        cyc();
        pv = 1'b0;
        chk("bp_next_req", req, 1);
        chk("bp_next_addr", addr, 32'h1C00_0008);

        // Flush while the request is still unaccepted.
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_req_held", req, 1);
        chk("fl_addr_held", addr, 32'h1C00_0008);
        cyc();
        addr_ok = 1'b1;
        cyc();
        addr_ok = 1'b0;
        #1;
        chk("fl_drop_allowin", allowin, 0);
        cyc();
        data_ok = 1'b1; rdata = 64'hDEAD_BEEF_CAFE_F00D;
        cyc();
        data_ok = 1'b0;
        #1;
        chk("fl_no_valid", vld, 0);
        chk("fl_allowin_back", allowin, 1);

        // Misaligned PC: immediate HOLD with adef, never touches the bus.
        pv = 1'b1; ppc = 32'h1C00_0002;
        cyc();
        pv = 1'b0; id_allow = 1'b0;
        chk("adef_req", req, 0);
        chk("adef_valid", vld, 1);
        chk("adef_flag", adef, 1);
        chk("adef_i1v", i1v, 0);
        cyc();
        chk("adef_req2", req, 0);
        id_allow = 1'b1;
        cyc();

        // Asynchronous reset in WAIT; the late data_ok must be ignored.
        pv = 1'b1; ppc = 32'h1C00_0010;
        cyc();
        pv = 1'b0; addr_ok = 1'b1;
        cyc();
        addr_ok = 1'b0;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async");
        model_clear();
        cyc();
        rst = 1'b0; data_ok = 1'b1; rdata = 64'h1111_2222_3333_4444;
        cyc();
        data_ok = 1'b0;
        chk("late_data_valid", vld, 0);
        cyc();

        // Random traffic with a legal bus: addr_ok only while a request is up,
        // data_ok only while a response is owed.
        for (int n = 0; n < 3000; n++) begin
            flush    = ($urandom_range(0, 15) == 0);
            pv       = ($urandom_range(0, 9) < 7);
            ppc      = 32'h1C00_0000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 7) == 0) ppc[1:0] = 2'($urandom_range(1, 3));
            id_allow = ($urandom_range(0, 3) != 0);
            addr_ok  = m_req  && ($urandom_range(0, 2) == 0);
            data_ok  = m_resp && ($urandom_range(0, 1) == 0);
            rdata    = {$urandom, $urandom};
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
